dna_decode_scheduler: RTL and testbench
=======================================

// Module: dna_decode_scheduler
// PURPOSE
// Shares one DNA-to-binary decoder among N_REQ requesters. Each requester hands in a
// 40-char ASCII strand (320 b). The block arbitrates round-robin, drives the decoder's
// start/dna inputs, and detects completion. It returns the 64-bit message on a single
// tagged response channel, with a timeout guard.
// PARAMETERS
// N_REQ     4    number of requesters (>=2); ID_W = $clog2(N_REQ), derived localparam
// DNA_W     320  strand width, 40 ASCII chars, MSB-first
// MSG_W     64   decoded message width
// TIMEOUT   64   max WAIT cycles before the job is aborted with error
// PORTS
// clk        in   1            clock
// resetN     in   1            async active-low reset
// req_valid  in   N_REQ        per-requester job request
// req_dna    in   N_REQ*DNA_W  strand of requester i at [i*DNA_W +: DNA_W]
// req_ready  out  N_REQ        one-hot accept; job transfers when valid&ready
// rsp_valid  out  1            response available
// rsp_ready  in   1            response consumer accept
// rsp_id     out  ID_W         index of the requester the response belongs to
// rsp_data   out  MSG_W        decoded message (0 on error)
// rsp_err    out  1            1 = decoder timed out
// dec_start  out  1            to decoder start (rising-edge sensitive)
// dec_dna    out  DNA_W        to decoder dna; held stable for the whole job
// dec_finish in   1            from decoder finish flag (level, sticky until next start)
// dec_msg    in   MSG_W        from decoder binary message
// BEHAVIOUR
// Reset: resetN is asynchronous, active-low; clk is the clock. Reset forces state=IDLE
//  and clears every output (req_ready, rsp_*, dec_start, dec_dna) to 0.
//  Reset also clears fin_d to 0 and sets rr_ptr so requester 0 has top priority.
// Reset mid-job drops the job silently. The decoder shares resetN and restarts too.
// FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//  IDLE: the grant goes to the first asserted req_valid, searching from rr_ptr upward
//   with wrap. req_ready[grant] is driven combinationally high in that cycle only.
//   req_ready is 0 in all other states.
//   On accept: latch dec_dna<=req_dna[grant], id<=grant, rr_ptr<=grant+1 (mod N_REQ).
//   Then go to ISSUE. With no valid request, stay in IDLE.
//  ISSUE: dec_start=1 for exactly this cycle. Clear the timeout counter. Go to WAIT.
//  WAIT: dec_start=0. fin_rise = dec_finish & ~fin_d, where fin_d is dec_finish
//   registered every cycle.
//   On fin_rise: rsp_data<=dec_msg, rsp_err<=0, go to RESP.
//   Otherwise, when the counter reaches TIMEOUT-1: rsp_data<=0, rsp_err<=1, go to RESP.
//   A fin_rise in the expiry cycle wins over the timeout.
//  RESP: rsp_valid=1. rsp_id, rsp_data and rsp_err stay stable until rsp_valid&rsp_ready.
//   On that handshake, rsp_valid goes to 0 and the FSM returns to IDLE.
//   The next request can be accepted on the following cycle.
// Sticky finish: a stale high dec_finish from the previous job is never treated as done.
//  Only a 0->1 edge seen in WAIT counts. Edges outside WAIT are ignored.
// Start low-time: dec_start is low for at least 1 cycle between pulses, so the
//  decoder's edge detector always sees a fresh edge.
// Latency with the standard decoder (3 cycles/byte x 8 bytes):
//  accept at cycle T, dec_start at T+1, dec_finish rises at T+26, rsp_valid at T+27.
// No queueing: at most one job in flight. Requests stay pending until granted.
// After a timeout, the decoder may still be running. System software must reset it
//  before reuse; this block does not track that.
// TESTING
// 1. One req on port 2, dna="AAAAA"x8 -> req_ready=4'b0100 for 1 cycle, one dec_start
//    pulse, rsp_valid at T+27, rsp_id=2, rsp_data=64'h0, rsp_err=0.
// 2. dna="TTATT"x8 on port 0 -> rsp_data=64'hFFFF_FFFF_FFFF_FFFF. dec_dna is constant
//    from T+1 until rsp handshake.
// 3. All 4 req_valid held high -> grant order 0,1,2,3,0. dec_start is low >=1 cycle
//    between pulses.
// 4. Decoder model never raises dec_finish -> rsp_valid exactly TIMEOUT cycles after
//    WAIT entry, rsp_err=1, rsp_data=0.
// 5. rsp_ready held low 10 cycles -> rsp_* stable, req_ready stays 0, no new dec_start.
//    Job completes on release.
// 6. resetN low during WAIT -> all outputs 0 immediately. After release, a new request
//    is served from port 0 priority.

Source files
------------

// File: rtl/dna_decode_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dna_decode_scheduler: round-robin sharing of one DNA decoder, tagged response, timeout
// Revision: 1.0
// ----------------------------------------------------------------------------
module dna_decode_scheduler #(
  parameter int N_REQ   = 4,
  parameter int DNA_W   = 320,
  parameter int MSG_W   = 64,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       resetN,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*DNA_W-1:0]     req_dna,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(N_REQ)-1:0]   rsp_id,
  output logic [MSG_W-1:0]           rsp_data,
  output logic                       rsp_err,
  output logic                       dec_start,
  output logic [DNA_W-1:0]           dec_dna,
  input  logic                       dec_finish,
  input  logic [MSG_W-1:0]           dec_msg
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t           state;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  grant;
  logic [ID_W-1:0]  scan;
  logic [ID_W-1:0]  grant_next;
  logic             grant_hit;
  logic             accept;
  logic             fin_d;
  logic             fin_rise;
  logic [CNT_W-1:0] wait_cnt;

  // Round-robin search starting at rr_ptr, wrapping at the last requester.
  always_comb begin
    grant     = rr_ptr;
    grant_hit = 1'b0;
    scan      = rr_ptr;
    for (int i = 0; i < N_REQ; i++) begin
      if (!grant_hit && req_valid[scan]) begin
        grant_hit = 1'b1;
        grant     = scan;
      end
      scan = (scan == LAST_ID) ? '0 : scan + ID_W'(1);
    end
  end

  assign grant_next = (grant == LAST_ID) ? '0 : grant + ID_W'(1);
  assign accept     = (state == IDLE) && grant_hit;
  assign fin_rise   = dec_finish && !fin_d;

  // Gated by resetN so the accept strobe is silent while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (accept && resetN) req_ready[grant] = 1'b1;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      dec_start <= 1'b0;
      dec_dna   <= '0;
      fin_d     <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      fin_d <= dec_finish;
      case (state)
        IDLE: begin
          if (accept) begin
            dec_dna   <= req_dna[int'(grant)*DNA_W +: DNA_W];
            rsp_id    <= grant;
            rr_ptr    <= grant_next;
            dec_start <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          dec_start <= 1'b0;
          wait_cnt  <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          // Only a fresh 0->1 edge counts; it also beats a same-cycle expiry.
          if (fin_rise) begin
            rsp_data  <= dec_msg;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (wait_cnt == CNT_LAST) begin
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dna_decode_scheduler.sv
`default_nettype none
// tb_dna_decode_scheduler: scoreboard bench driving the scheduler against a
// behavioural 3-cycles-per-byte decoder model.
module tb_dna_decode_scheduler;

  localparam int N_REQ   = 4;
  localparam int DNA_W   = 320;
  localparam int MSG_W   = 64;
  localparam int TIMEOUT = 64;
  localparam int ID_W    = 2;
  localparam logic [39:0] G_A = "AAAAA";
  localparam logic [39:0] G_T = "TTATT";

  logic                   clk       = 1'b0;
  logic                   resetN    = 1'b0;
  logic [N_REQ-1:0]       req_valid = '0;
  logic [N_REQ*DNA_W-1:0] req_dna   = '0;
  logic [N_REQ-1:0]       req_ready;
  logic                   rsp_valid;
  logic                   rsp_ready = 1'b1;
  logic [ID_W-1:0]        rsp_id;
  logic [MSG_W-1:0]       rsp_data;
  logic                   rsp_err;
  logic                   dec_start;
  logic [DNA_W-1:0]       dec_dna;
  logic                   dec_finish;
  logic [MSG_W-1:0]       dec_msg;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [MSG_W-1:0] data;
    logic             err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  logic hang = 1'b0;
  logic lazy = 1'b0;
  logic start_d;
  logic busy;
  int   dcnt;

  dna_decode_scheduler #(
    .N_REQ(N_REQ), .DNA_W(DNA_W), .MSG_W(MSG_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .resetN(resetN),
    .req_valid(req_valid), .req_dna(req_dna), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .dec_start(dec_start), .dec_dna(dec_dna),
    .dec_finish(dec_finish), .dec_msg(dec_msg)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Five-char groups map to one byte, MSB group first.
  function automatic logic [MSG_W-1:0] model_msg(input logic [DNA_W-1:0] d);
    logic [MSG_W-1:0] m;
    logic [39:0]      g;
    logic [7:0]       b;
    m = '0;
    for (int k = 0; k < 8; k++) begin
      g = d[DNA_W-1-40*k -: 40];
      if (g == G_A)      b = 8'h00;
      else if (g == G_T) b = 8'hFF;
      else               b = g[39:32] ^ g[31:24] ^ g[23:16] ^ g[15:8] ^ g[7:0];
      m = {m[MSG_W-9:0], b};
    end
    return m;
  endfunction

  function automatic logic [DNA_W-1:0] rand_dna();
    logic [31:0]      acgt;
    logic [DNA_W-1:0] d;
    acgt = "ACGT";
    for (int i = 0; i < 40; i++) d[i*8 +: 8] = acgt[8*$urandom_range(0, 3) +: 8];
    return d;
  endfunction

  // Decoder model: finish rises 24 cycles after it sees the start edge and stays
  // high until the next start; 'lazy' keeps the stale finish for 2 extra cycles.
  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      dec_finish <= 1'b0;
      dec_msg    <= '0;
      start_d    <= 1'b0;
      busy       <= 1'b0;
      dcnt       <= 0;
    end else begin
      start_d <= dec_start;
      if (dec_start && !start_d) begin
        if (!lazy) dec_finish <= 1'b0;
        busy    <= !hang;
        dcnt    <= 0;
        dec_msg <= model_msg(dec_dna);
      end else if (busy) begin
        dcnt <= dcnt + 1;
        if (lazy && dcnt == 1) dec_finish <= 1'b0;
        if (dcnt == 23) begin
          dec_finish <= 1'b1;
          busy       <= 1'b0;
        end
      end
    end
  end

  task automatic set_dna(input int p, input logic [DNA_W-1:0] d);
    req_dna[p*DNA_W +: DNA_W] = d;
  endtask

  task automatic push_exp(input logic [ID_W-1:0] id, input logic [MSG_W-1:0] data, input logic err);
    exp_t e;
    e.id = id; e.data = data; e.err = err;
    sb.push_back(e);
  endtask

  task automatic pop_exp(output exp_t e, output bit ok);
    ok = (sb.size() != 0);
    e  = ok ? sb.pop_front() : '0;
  endtask

  // Returns at negedge+1 of the accept cycle; t = that cycle number.
  task automatic wait_accept(input int budget, output bit ok, output int t);
    ok = 1'b0; t = 0;
    for (int c = 0; c < budget; c++) begin
      #1;
      if (|(req_valid & req_ready)) begin
        ok = 1'b1; t = cyc;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_rsp(input int budget, output bit ok, output int t, output int starts);
    ok = 1'b0; t = 0; starts = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (dec_start) starts++;
      if (rsp_valid) begin
        ok = 1'b1; t = cyc;
        return;
      end
    end
  endtask

  task automatic test_reset();
    req_valid = '1;
    repeat (2) @(negedge clk);
    checks++;
    if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    checks++;
    if ({rsp_id, rsp_data, rsp_err} !== '0) begin
      errors++; $display("FAIL reset_rsp_fields: got id=%0d data=%h err=%b want all 0", rsp_id, rsp_data, rsp_err);
    end
    checks++;
    if ({dec_start, dec_dna} !== '0) begin
      errors++; $display("FAIL reset_dec: got start=%b dna=%h want 0", dec_start, dec_dna);
    end
    @(negedge clk);
    resetN    = 1'b1;
    req_valid = '0;
  endtask

  task automatic test_round_robin();
    logic [DNA_W-1:0] d [N_REQ];
    logic [N_REQ-1:0] want;
    int   ng = 0, nr = 0, pulses = 0, gap_bad = 0;
    logic prev = 1'b0;
    bit   drop = 1'b0, ok;
    exp_t e;
    @(negedge clk);
    for (int p = 0; p < N_REQ; p++) begin
      d[p] = rand_dna();
      set_dna(p, d[p]);
    end
    for (int k = 0; k < 5; k++) push_exp(ID_W'(k % N_REQ), model_msg(d[k % N_REQ]), 1'b0);
    req_valid = '1;
    for (int c = 0; c < 600 && nr < 5; c++) begin
      if (c > 0) @(negedge clk);
      if (drop) begin req_valid = '0; drop = 1'b0; end
      if (dec_start && prev) gap_bad++;
      prev = dec_start;
      if (dec_start) pulses++;
      if (rsp_valid) begin
        pop_exp(e, ok);
        checks++;
        if (!ok || {rsp_id, rsp_data, rsp_err} !== e) begin
          errors++;
          $display("FAIL rr_rsp%0d: got id=%0d data=%h err=%b want id=%0d data=%h err=%b",
                   nr, rsp_id, rsp_data, rsp_err, e.id, e.data, e.err);
        end
        nr++;
      end
      #1;
      if (|(req_valid & req_ready)) begin
        want = '0;
        want[ng % N_REQ] = 1'b1;
        checks++;
        if (req_ready !== want) begin
          errors++; $display("FAIL rr_grant%0d: got %b want %b", ng, req_ready, want);
        end
        ng++;
        if (ng == 5) drop = 1'b1;
      end
    end
    checks++;
    if (nr != 5 || ng != 5) begin errors++; $display("FAIL rr_count: got %0d grants %0d rsps want 5 5", ng, nr); end
    checks++;
    if (pulses != 5 || gap_bad != 0) begin
      errors++; $display("FAIL rr_start_pulses: got %0d pulses %0d gaps missing want 5 0", pulses, gap_bad);
    end
  endtask

  task automatic test_single_aaaaa();
    bit   ok;
    int   t0, t1, ns;
    exp_t e;
    @(negedge clk);
    set_dna(2, {8{G_A}});
    req_valid = 4'b0100;
    push_exp(2'd2, 64'h0, 1'b0);
    wait_accept(5, ok, t0);
    checks++;
    if (!ok || req_ready !== 4'b0100) begin errors++; $display("FAIL p2_grant: got %b want 0100", req_ready); end
    @(negedge clk);
    req_valid = '0;
    checks++;
    if (dec_start !== 1'b1 || req_ready !== '0) begin
      errors++; $display("FAIL p2_issue: got start=%b ready=%b want 1 0000", dec_start, req_ready);
    end
    wait_rsp(100, ok, t1, ns);
    checks++;
    if (!ok || t1 - t0 != 27) begin errors++; $display("FAIL p2_latency: got %0d want 27 (seen=%0d)", t1 - t0, ok); end
    checks++;
    if (ns != 0) begin errors++; $display("FAIL p2_single_start: got %0d extra start cycles want 0", ns); end
    pop_exp(e, ok);
    checks++;
    if (!ok || {rsp_id, rsp_data, rsp_err} !== e) begin
      errors++; $display("FAIL p2_rsp: got id=%0d data=%h err=%b want id=2 data=0 err=0", rsp_id, rsp_data, rsp_err);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL p2_rsp_clear: got %b want 0", rsp_valid); end
  endtask

  task automatic test_ttatt_stale_finish();
    logic [DNA_W-1:0] d;
    bit   ok = 1'b0;
    int   t0, t1 = 0, bad = 0;
    exp_t e;
    @(negedge clk);
    lazy = 1'b1;
    d = {8{G_T}};
    for (int p = 1; p < N_REQ; p++) set_dna(p, rand_dna());
    set_dna(0, d);
    req_valid = 4'b0001;
    push_exp(2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    wait_accept(5, ok, t0);
    checks++;
    if (!ok || req_ready !== 4'b0001) begin errors++; $display("FAIL p0_grant: got %b want 0001", req_ready); end
    ok = 1'b0;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge clk);
      req_valid = '0;
      if (dec_dna !== d) bad++;
      if (rsp_valid) begin ok = 1'b1; t1 = cyc; end
    end
    checks++;
    if (!ok || t1 - t0 != 27) begin errors++; $display("FAIL p0_latency_stale_finish: got %0d want 27", t1 - t0); end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL p0_dna_stable: got %0d bad cycles want 0", bad); end
    pop_exp(e, ok);
    checks++;
    if (!ok || {rsp_id, rsp_data, rsp_err} !== e) begin
      errors++; $display("FAIL p0_rsp: got id=%0d data=%h err=%b want id=0 data=%h err=0", rsp_id, rsp_data, rsp_err, e.data);
    end
    @(negedge clk);
    lazy = 1'b0;
  endtask

  task automatic test_timeout();
    bit   ok;
    int   t0, t1, ns;
    exp_t e;
    @(negedge clk);
    hang = 1'b1;
    set_dna(1, rand_dna());
    req_valid = 4'b0010;
    push_exp(2'd1, 64'h0, 1'b1);
    wait_accept(5, ok, t0);
    @(negedge clk);
    req_valid = '0;
    wait_rsp(300, ok, t1, ns);
    checks++;
    if (!ok || t1 - (t0 + 2) != TIMEOUT) begin
      errors++; $display("FAIL timeout_latency: got %0d want %0d (seen=%0d)", t1 - (t0 + 2), TIMEOUT, ok);
    end
    pop_exp(e, ok);
    checks++;
    if (!ok || {rsp_id, rsp_data, rsp_err} !== e) begin
      errors++; $display("FAIL timeout_rsp: got id=%0d data=%h err=%b want id=1 data=0 err=1", rsp_id, rsp_data, rsp_err);
    end
    @(negedge clk);
    hang = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [DNA_W-1:0] d3, d1;
    logic [ID_W+MSG_W:0] snap;
    bit   ok;
    int   t0, t1, ns, unstable = 0, busy_bad = 0;
    exp_t e;
    @(negedge clk);
    d3 = rand_dna(); d1 = rand_dna();
    set_dna(3, d3); set_dna(1, d1);
    rsp_ready = 1'b0;
    req_valid = 4'b1000;
    push_exp(2'd3, model_msg(d3), 1'b0);
    push_exp(2'd1, model_msg(d1), 1'b0);
    wait_accept(5, ok, t0);
    @(negedge clk);
    req_valid = 4'b0010;
    wait_rsp(100, ok, t1, ns);
    snap = {rsp_id, rsp_data, rsp_err};
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      if (!rsp_valid || {rsp_id, rsp_data, rsp_err} !== snap) unstable++;
      if (req_ready !== '0 || dec_start !== 1'b0) busy_bad++;
    end
    checks++;
    if (!ok || unstable != 0) begin errors++; $display("FAIL bp_hold_stable: got %0d unstable cycles want 0", unstable); end
    checks++;
    if (busy_bad != 0) begin errors++; $display("FAIL bp_no_new_job: got %0d bad cycles want 0", busy_bad); end
    rsp_ready = 1'b1;
    pop_exp(e, ok);
    checks++;
    if (!ok || {rsp_id, rsp_data, rsp_err} !== e) begin
      errors++; $display("FAIL bp_rsp: got id=%0d data=%h err=%b want id=3 data=%h err=0", rsp_id, rsp_data, rsp_err, e.data);
    end
    @(negedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b0010) begin
      errors++; $display("FAIL bp_next_accept: got valid=%b ready=%b want 0 0010", rsp_valid, req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    wait_rsp(100, ok, t1, ns);
    pop_exp(e, ok);
    checks++;
    if (!ok || {rsp_id, rsp_data, rsp_err} !== e) begin
      errors++; $display("FAIL bp_second_rsp: got id=%0d data=%h err=%b want id=1 data=%h err=0", rsp_id, rsp_data, rsp_err, e.data);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_job();
    logic [DNA_W-1:0] d0;
    bit   ok;
    int   t0, t1, ns;
    exp_t e;
    @(negedge clk);
    set_dna(2, rand_dna());
    req_valid = 4'b0100;
    wait_accept(5, ok, t0);
    @(negedge clk);
    req_valid = 4'b1010;
    repeat (5) @(negedge clk);
    resetN = 1'b0;
    #1;
    checks++;
    if (req_ready !== '0 || rsp_valid !== 1'b0 || dec_start !== 1'b0) begin
      errors++; $display("FAIL midreset_ctrl: got ready=%b valid=%b start=%b want 0", req_ready, rsp_valid, dec_start);
    end
    checks++;
    if ({rsp_id, rsp_data, rsp_err} !== '0 || dec_dna !== '0) begin
      errors++; $display("FAIL midreset_data: got id=%0d data=%h err=%b dna_nonzero=%b want 0", rsp_id, rsp_data, rsp_err, |dec_dna);
    end
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    d0 = rand_dna();
    set_dna(0, d0);
    req_valid = 4'b1101;
    push_exp(2'd0, model_msg(d0), 1'b0);
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL midreset_priority: got %b want 0001", req_ready); end
    t0 = cyc;
    @(negedge clk);
    req_valid = '0;
    wait_rsp(100, ok, t1, ns);
    checks++;
    if (!ok || t1 - t0 != 27) begin errors++; $display("FAIL midreset_latency: got %0d want 27", t1 - t0); end
    pop_exp(e, ok);
    checks++;
    if (!ok || {rsp_id, rsp_data, rsp_err} !== e) begin
      errors++; $display("FAIL midreset_rsp: got id=%0d data=%h err=%b want id=0 data=%h err=0", rsp_id, rsp_data, rsp_err, e.data);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_aaaaa();
    test_ttatt_stale_finish();
    test_timeout();
    test_backpressure();
    test_reset_mid_job();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_drained: got %0d left want 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
